// File: rtl/altmemddr_bridge_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the DDR clock-crossing bridge
// slave port. Round-robin grant with parking. Outstanding reads are tracked
// in issue order so that each bridge response returns to the master that
// issued the read.
module altmemddr_bridge_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4,
    parameter int MAX_PENDING = 16,
    parameter int CNT_W       = 5
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    // requester 0
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    // requester 1
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    // bridge slave port
    output logic [ADDR_W-1:0] br_address,
    output logic [BE_W-1:0]   br_byteenable,
    output logic              br_read,
    output logic              br_write,
    output logic [DATA_W-1:0] br_writedata,
    input  logic              br_waitrequest,
    input  logic [DATA_W-1:0] br_readdata,
    input  logic              br_readdatavalid,
    // status
    output logic [CNT_W-1:0]  pending_count,
    output logic              rsp_underflow
);

    localparam int PTR_W = CNT_W - 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_nxt;

    logic             last_grant;
    logic             req0, req1;
    logic             full, empty;
    logic             read_block;
    logic             accept;
    logic             push, pop;
    logic             head_id;
    logic [MAX_PENDING-1:0] id_fifo;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign full  = (pending_count == CNT_W'(MAX_PENDING));
    assign empty = (pending_count == '0);

    // Grant register; the arbitration decision takes effect next cycle
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    // Bridge mux, stall generation and next-grant selection
    always_comb begin
        state_nxt      = state;
        br_address     = '0;
        br_byteenable  = '0;
        br_writedata   = '0;
        br_read        = 1'b0;
        br_write       = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        read_block     = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0: begin
                read_block     = m0_read & full;
                br_address     = m0_address;
                br_byteenable  = m0_byteenable;
                br_writedata   = m0_writedata;
                br_read        = m0_read & ~read_block;
                br_write       = m0_write;
                m0_waitrequest = br_waitrequest | read_block;
                accept         = (br_read | br_write) & ~br_waitrequest;
                if ((accept || !req0) && req1) state_nxt = GNT1;
            end
            GNT1: begin
                read_block     = m1_read & full;
                br_address     = m1_address;
                br_byteenable  = m1_byteenable;
                br_writedata   = m1_writedata;
                br_read        = m1_read & ~read_block;
                br_write       = m1_write;
                m1_waitrequest = br_waitrequest | read_block;
                accept         = (br_read | br_write) & ~br_waitrequest;
                if ((accept || !req1) && req0) state_nxt = GNT0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remember who was served last so the next tie goes to the other one
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n)  last_grant <= 1'b1;
        else if (accept)     last_grant <= (state == GNT1);
    end

    assign push    = accept & br_read;
    assign pop     = br_readdatavalid & ~empty;
    assign head_id = id_fifo[rd_ptr];

    // Issue-order ID FIFO; pointers wrap naturally at MAX_PENDING
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            id_fifo       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= (state == GNT1);
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Sticky flag for a response with nothing outstanding (dropped)
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n)                    rsp_underflow <= 1'b0;
        else if (br_readdatavalid && empty)    rsp_underflow <= 1'b1;
    end

    assign m0_readdata      = br_readdata;
    assign m1_readdata      = br_readdata;
    assign m0_readdatavalid = br_readdatavalid & ~empty & ~head_id;
    assign m1_readdatavalid = br_readdatavalid & ~empty &  head_id;

endmodule

// File: tb/tb_altmemddr_bridge_arbiter.sv
// Directed bench for altmemddr_bridge_arbiter. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
module tb_altmemddr_bridge_arbiter;

    logic        slave_clk = 1'b0;
    logic        slave_reset_n;
    logic [23:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [23:0] br_address;
    logic [3:0]  br_byteenable;
    logic        br_read, br_write;
    logic [31:0] br_writedata;
    logic        br_waitrequest;
    logic [31:0] br_readdata;
    logic        br_readdatavalid;
    logic [4:0]  pending_count;
    logic        rsp_underflow;

    int total = 0;
    int bad   = 0;

    altmemddr_bridge_arbiter dut (
        .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .br_address(br_address), .br_byteenable(br_byteenable), .br_read(br_read),
        .br_write(br_write), .br_writedata(br_writedata), .br_waitrequest(br_waitrequest),
        .br_readdata(br_readdata), .br_readdatavalid(br_readdatavalid),
        .pending_count(pending_count), .rsp_underflow(rsp_underflow)
    );

    always #5 slave_clk = ~slave_clk;

    task automatic step();
        @(posedge slave_clk); #1;
    endtask

    task automatic test_reset();
        slave_reset_n = 1'b0;
        m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_writedata = '0; m1_writedata = '0;
        br_waitrequest = 0; br_readdata = '0; br_readdatavalid = 0;
        step(); step();
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b11) begin bad++; $display("FAIL rst_waitreq got=%b exp=11", {m1_waitrequest, m0_waitrequest}); end
        total++; if ({br_read, br_write} !== 2'b00) begin bad++; $display("FAIL rst_br_cmd got=%b exp=00", {br_read, br_write}); end
        total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL rst_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
        total++; if (pending_count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", pending_count); end
        total++; if (rsp_underflow !== 1'b0) begin bad++; $display("FAIL rst_underflow got=%b exp=0", rsp_underflow); end
        step();
        slave_reset_n = 1'b1;
    endtask

    task automatic test_first_write();
        m0_write = 1; m0_address = 24'h000010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge slave_clk);
        total++; if ({m0_waitrequest, br_write} !== 2'b10) begin bad++; $display("FAIL wr_idle got=%b exp=10", {m0_waitrequest, br_write}); end
        step();
        @(negedge slave_clk);
        total++; if ({m0_waitrequest, br_write} !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b exp=01", {m0_waitrequest, br_write}); end
        total++; if (br_address !== 24'h000010) begin bad++; $display("FAIL wr_addr got=%h exp=000010", br_address); end
        total++; if (br_writedata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", br_writedata); end
        total++; if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_m1_stall got=%b exp=1", m1_waitrequest); end
        step();
        m0_write = 0;
        @(negedge slave_clk);
        total++; if (br_write !== 1'b0) begin bad++; $display("FAIL wr_one_cycle got=%b exp=0", br_write); end
        total++; if (pending_count !== 5'd0) begin bad++; $display("FAIL wr_count got=%0d exp=0", pending_count); end
        step();
    endtask

    // Both masters read every cycle; bridge answers one cycle after accept
    task automatic test_round_robin();
        logic [32:0] q[$];
        logic [23:0] a0 = 24'h000100;
        logic [23:0] a1 = 24'h000200;
        logic [31:0] tag = 32'hC0DE0000;
        int g;
        for (int i = 0; i < 9; i++) begin
            m0_read = (i < 8); m1_read = (i < 8); m0_address = a0; m1_address = a1;
            br_readdatavalid = (q.size() > 0);
            br_readdata = (q.size() > 0) ? q[0][31:0] : 32'h0;
            @(negedge slave_clk);
            g = i % 2;
            total++; if (pending_count !== 5'(q.size())) begin bad++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", i, pending_count, q.size()); end
            if (i < 8) begin
                total++; if (br_read !== 1'b1) begin bad++; $display("FAIL rr_br_read[%0d] got=%b exp=1", i, br_read); end
                total++; if (br_address !== (g ? a1 : a0)) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, br_address, g ? a1 : a0); end
                total++; if ({m1_waitrequest, m0_waitrequest} !== (g ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {m1_waitrequest, m0_waitrequest}, g ? 2'b01 : 2'b10); end
            end
            if (q.size() > 0) begin
                total++; if ({m1_readdatavalid, m0_readdatavalid} !== (q[0][32] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_route[%0d] got=%b exp=%b", i, {m1_readdatavalid, m0_readdatavalid}, q[0][32] ? 2'b10 : 2'b01); end
                total++; if (m0_readdata !== q[0][31:0] || m1_readdata !== q[0][31:0]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, m0_readdata, q[0][31:0]); end
                void'(q.pop_front());
            end
            if (i < 8) begin
                q.push_back({g[0], tag});
                tag++;
                if (g == 0) a0++; else a1++;
            end
            step();
        end
        br_readdatavalid = 0; m0_read = 0; m1_read = 0;
    endtask

    // Fill to MAX_PENDING, block reads, let a write through, unblock by one pop
    task automatic test_pending_limit();
        m0_read = 1; m0_address = 24'h000400;
        for (int i = 0; i < 16; i++) begin
            @(negedge slave_clk);
            total++; if ({br_read, m0_waitrequest} !== 2'b10 || pending_count !== 5'(i)) begin bad++; $display("FAIL fill[%0d] got=%b/%0d exp=10/%0d", i, {br_read, m0_waitrequest}, pending_count, i); end
            step();
            m0_address++;
        end
        @(negedge slave_clk);
        total++; if (pending_count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", pending_count); end
        total++; if ({br_read, m0_waitrequest} !== 2'b01) begin bad++; $display("FAIL full_block got=%b exp=01", {br_read, m0_waitrequest}); end
        step();
        m0_read = 0; m1_write = 1; m1_address = 24'h000300; m1_writedata = 32'h12345678;
        step();
        @(negedge slave_clk);
        total++; if ({br_write, m1_waitrequest} !== 2'b10) begin bad++; $display("FAIL full_write got=%b exp=10", {br_write, m1_waitrequest}); end
        total++; if (br_writedata !== 32'h12345678) begin bad++; $display("FAIL full_wdata got=%h exp=12345678", br_writedata); end
        step();
        m1_write = 0; m0_read = 1;
        step();
        br_readdatavalid = 1; br_readdata = 32'hAAAA0001;
        @(negedge slave_clk);
        total++; if ({m0_readdatavalid, m0_waitrequest, br_read} !== 3'b110) begin bad++; $display("FAIL full_pop_block got=%b exp=110", {m0_readdatavalid, m0_waitrequest, br_read}); end
        step();
        br_readdatavalid = 0;
        @(negedge slave_clk);
        total++; if (pending_count !== 5'd15) begin bad++; $display("FAIL after_pop_count got=%0d exp=15", pending_count); end
        total++; if ({m0_waitrequest, br_read} !== 2'b01) begin bad++; $display("FAIL unblock got=%b exp=01", {m0_waitrequest, br_read}); end
        step();
        m0_read = 0;
        for (int k = 0; k < 16; k++) begin
            br_readdatavalid = 1;
            @(negedge slave_clk);
            total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01 || pending_count !== 5'(16 - k)) begin bad++; $display("FAIL drain[%0d] got=%b/%0d exp=01/%0d", k, {m1_readdatavalid, m0_readdatavalid}, pending_count, 16 - k); end
            step();
        end
        br_readdatavalid = 0;
    endtask

    // Five reads in flight, then alternating reads with five-cycle latency
    task automatic test_wrap_mixed();
        logic [32:0] q[$];
        logic [31:0] tag = 32'h50000000;
        int g;
        for (int i = 0; i < 50; i++) begin
            m0_read = (i < 45); m1_read = (i >= 5 && i < 45);
            m0_address = 24'(i); m1_address = 24'(i + 1000);
            br_readdatavalid = (i >= 5 && q.size() > 0);
            br_readdata = (q.size() > 0) ? q[0][31:0] : 32'h0;
            @(negedge slave_clk);
            g = (i < 5) ? 0 : ((i - 5) % 2);
            total++; if (pending_count !== 5'(q.size())) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, pending_count, q.size()); end
            if (i >= 5 && i < 45) begin
                total++; if (pending_count !== 5'd5) begin bad++; $display("FAIL pushpop_count[%0d] got=%0d exp=5", i, pending_count); end
            end
            if (i < 45) begin
                total++; if ({m1_waitrequest, m0_waitrequest} !== (g ? 2'b01 : 2'b10) || br_read !== 1'b1) begin bad++; $display("FAIL wrap_grant[%0d] got=%b exp=%b", i, {m1_waitrequest, m0_waitrequest}, g ? 2'b01 : 2'b10); end
            end
            if (i >= 5 && q.size() > 0) begin
                total++; if ({m1_readdatavalid, m0_readdatavalid} !== (q[0][32] ? 2'b10 : 2'b01) || m0_readdata !== q[0][31:0]) begin bad++; $display("FAIL wrap_route[%0d] got=%b/%h exp=%b/%h", i, {m1_readdatavalid, m0_readdatavalid}, m0_readdata, q[0][32] ? 2'b10 : 2'b01, q[0][31:0]); end
                void'(q.pop_front());
            end
            if (i < 45) begin
                q.push_back({g[0], tag});
                tag++;
            end
            step();
        end
        br_readdatavalid = 0; m0_read = 0; m1_read = 0;
    endtask

    // Bridge stall holds the m1 command and the grant; accept then moves on
    task automatic test_back_to_back();
        br_waitrequest = 1; m1_read = 1; m1_address = 24'h000777;
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, br_read} !== 2'b10) begin bad++; $display("FAIL stall_pre got=%b exp=10", {m1_waitrequest, br_read}); end
        step();
        m0_read = 1; m0_address = 24'h000555;
        for (int i = 0; i < 10; i++) begin
            @(negedge slave_clk);
            total++; if ({br_read, m1_waitrequest, m0_waitrequest} !== 3'b111 || br_address !== 24'h000777) begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=111/000777", i, {br_read, m1_waitrequest, m0_waitrequest}, br_address); end
            step();
        end
        br_waitrequest = 0;
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b01 || br_address !== 24'h000777) begin bad++; $display("FAIL stall_release got=%b/%h exp=01/000777", {m1_waitrequest, m0_waitrequest}, br_address); end
        step();
        m1_read = 0;
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10 || br_address !== 24'h000555) begin bad++; $display("FAIL stall_switch got=%b/%h exp=10/000555", {m1_waitrequest, m0_waitrequest}, br_address); end
        total++; if (pending_count !== 5'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", pending_count); end
        step();
        m0_read = 0; br_readdatavalid = 1; br_readdata = 32'h11;
        @(negedge slave_clk);
        total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) begin bad++; $display("FAIL stall_rsp1 got=%b exp=10", {m1_readdatavalid, m0_readdatavalid}); end
        step();
        br_readdata = 32'h22;
        @(negedge slave_clk);
        total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b01) begin bad++; $display("FAIL stall_rsp2 got=%b exp=01", {m1_readdatavalid, m0_readdatavalid}); end
        step();
        br_readdatavalid = 0;
    endtask

    // Reset with reads in flight; late responses become underflows; tie from IDLE
    task automatic test_reset_midop();
        m0_read = 1; m0_address = 24'h000900;
        step(); step(); step();
        m0_read = 0;
        @(negedge slave_clk);
        total++; if (pending_count !== 5'd3) begin bad++; $display("FAIL mid_count got=%0d exp=3", pending_count); end
        step();
        slave_reset_n = 0;
        @(negedge slave_clk);
        total++; if (pending_count !== 5'd0 || m0_waitrequest !== 1'b1 || rsp_underflow !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/1/0", pending_count, m0_waitrequest, rsp_underflow); end
        step();
        slave_reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            br_readdatavalid = 1; br_readdata = 32'(i);
            @(negedge slave_clk);
            total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL late_rsp[%0d] got=%b exp=00", i, {m1_readdatavalid, m0_readdatavalid}); end
            step();
        end
        br_readdatavalid = 0;
        @(negedge slave_clk);
        total++; if (rsp_underflow !== 1'b1 || pending_count !== 5'd0) begin bad++; $display("FAIL underflow got=%b/%0d exp=1/0", rsp_underflow, pending_count); end
        step();
        m0_write = 1; m0_address = 24'h0000A0; m1_write = 1; m1_address = 24'h0000B0;
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest, br_write} !== 3'b110) begin bad++; $display("FAIL tie_idle got=%b exp=110", {m1_waitrequest, m0_waitrequest, br_write}); end
        step();
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10 || br_address !== 24'h0000A0) begin bad++; $display("FAIL tie_first got=%b/%h exp=10/0000a0", {m1_waitrequest, m0_waitrequest}, br_address); end
        step();
        m0_write = 0;
        @(negedge slave_clk);
        total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b01 || br_address !== 24'h0000B0) begin bad++; $display("FAIL tie_second got=%b/%h exp=01/0000b0", {m1_waitrequest, m0_waitrequest}, br_address); end
        step();
        m1_write = 0;
        @(negedge slave_clk);
        total++; if (rsp_underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b exp=1", rsp_underflow); end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_round_robin();
        test_pending_limit();
        test_wrap_mixed();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
